// File: rtl/match_sequencer.sv
// Foosball match flow controller: sequences kickoff/play/pause/goal/over, keeps scores,
// gates the one-second tick into the match timer and issues reload/ball-reset pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_key, scores held at zero
// KICKOFF  | ball placed at centre, counting KICKOFF_SEC seconds
// PLAYING  | live play, one_sec forwarded as timer_tick
// PAUSED   | play frozen until pause_key
// GOAL     | celebration, counting GOAL_PAUSE_SEC seconds
// OVER     | match finished, winner held until start_key
module match_sequencer #(
  parameter int WIN_SCORE      = 5,
  parameter int GOAL_PAUSE_SEC = 3,
  parameter int KICKOFF_SEC    = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       one_sec,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       time_up,
  output logic       timer_tick,
  output logic       timer_load,
  output logic       ball_reset,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic       play_active,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICKOFF = 3'd1,
    S_PLAYING = 3'd2,
    S_PAUSED  = 3'd3,
    S_GOAL    = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [3:0] WIN_Q     = 4'(WIN_SCORE);
  localparam logic [3:0] GOAL_SECS = 4'(GOAL_PAUSE_SEC);
  localparam logic [3:0] KICK_SECS = 4'(KICKOFF_SEC);

  state_t     state_q, state_d;
  logic [3:0] sec_cnt_q, sec_cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [1:0] winner_q, winner_d;
  logic       tick_q, tick_d;
  logic       load_q, load_d;
  logic       ball_q, ball_d;
  logic       play_q, over_q;

  logic [3:0] new_l, new_r;
  logic [1:0] new_winner;
  logic       any_goal;

  // Scores saturate at 15; new_* are the post-goal scores used for the win check.
  always_comb begin
    new_l = score_l_q;
    new_r = score_r_q;
    if (goal_left && score_l_q != 4'hF) new_l = score_l_q + 4'd1;
    if (goal_right && score_r_q != 4'hF) new_r = score_r_q + 4'd1;
    any_goal = goal_left | goal_right;
    if (new_l > new_r)      new_winner = 2'b01;
    else if (new_r > new_l) new_winner = 2'b10;
    else                    new_winner = 2'b11;
  end

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    tick_d    = 1'b0;
    load_d    = 1'b0;
    ball_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        score_l_d = 4'd0;
        score_r_d = 4'd0;
        winner_d  = 2'b00;
        if (start_key) begin
          state_d   = S_KICKOFF;
          load_d    = 1'b1;
          ball_d    = 1'b1;
          sec_cnt_d = KICK_SECS;
        end
      end
      S_KICKOFF: begin
        if (one_sec) begin
          if (sec_cnt_q <= 4'd1) begin
            state_d   = S_PLAYING;
            sec_cnt_d = 4'd0;
          end else begin
            sec_cnt_d = sec_cnt_q - 4'd1;
          end
        end
      end
      S_PLAYING: begin
        tick_d = one_sec;
        if (any_goal) begin
          score_l_d = new_l;
          score_r_d = new_r;
          if (new_l >= WIN_Q || new_r >= WIN_Q || time_up) begin
            state_d  = S_OVER;
            winner_d = new_winner;
          end else begin
            state_d   = S_GOAL;
            sec_cnt_d = GOAL_SECS;
          end
        end else if (time_up) begin
          state_d  = S_OVER;
          winner_d = new_winner;
        end else if (pause_key) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_key) state_d = S_PLAYING;
      end
      S_GOAL: begin
        if (one_sec) begin
          if (sec_cnt_q <= 4'd1) begin
            state_d   = S_KICKOFF;
            ball_d    = 1'b1;
            sec_cnt_d = KICK_SECS;
          end else begin
            sec_cnt_d = sec_cnt_q - 4'd1;
          end
        end
      end
      S_OVER: begin
        if (start_key) begin
          state_d   = S_IDLE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      sec_cnt_q <= 4'd0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      winner_q  <= 2'b00;
      tick_q    <= 1'b0;
      load_q    <= 1'b0;
      ball_q    <= 1'b0;
      play_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      tick_q    <= tick_d;
      load_q    <= load_d;
      ball_q    <= ball_d;
      play_q    <= (state_d == S_PLAYING);
      over_q    <= (state_d == S_OVER);
    end
  end

  assign state       = state_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;
  assign timer_tick  = tick_q;
  assign timer_load  = load_q;
  assign ball_reset  = ball_q;
  assign play_active = play_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: a vector table for the main flow plus
// hand sequences for winning, simultaneous goals with time_up, and mid-GOAL reset.
module tb_match_sequencer;

  logic       clk, resetN;
  logic       start_key, pause_key, one_sec, goal_left, goal_right, time_up;
  logic       timer_tick, timer_load, ball_reset, play_active, game_over;
  logic [3:0] score_left, score_right;
  logic [2:0] state;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;

  match_sequencer #(.WIN_SCORE(5), .GOAL_PAUSE_SEC(3), .KICKOFF_SEC(1)) dut (
    .clk(clk), .resetN(resetN), .start_key(start_key), .pause_key(pause_key),
    .one_sec(one_sec), .goal_left(goal_left), .goal_right(goal_right), .time_up(time_up),
    .timer_tick(timer_tick), .timer_load(timer_load), .ball_reset(ball_reset),
    .score_left(score_left), .score_right(score_right), .state(state),
    .play_active(play_active), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_PAUSE = 6'b010000;
  localparam logic [5:0] I_SEC   = 6'b001000;
  localparam logic [5:0] I_GL    = 6'b000100;
  localparam logic [5:0] I_GR    = 6'b000010;
  localparam logic [5:0] I_TUP   = 6'b000001;

  typedef struct {
    logic [5:0]  in;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs [23];
  logic [17:0] obs;

  // Packed view: state, tick, load, ball, score_left, score_right, winner, play_active, game_over.
  assign obs = {state, timer_tick, timer_load, ball_reset, score_left, score_right,
                winner, play_active, game_over};

  function automatic logic [17:0] mk(int st, int tick, int load, int ball, int sl, int sr,
                                     int win, int pa, int go);
    return {3'(st), 1'(tick), 1'(load), 1'(ball), 4'(sl), 4'(sr), 2'(win), 1'(pa), 1'(go)};
  endfunction

  task automatic drive(input logic [5:0] v);
    {start_key, pause_key, one_sec, goal_left, goal_right, time_up} = v;
  endtask

  task automatic step(input logic [5:0] v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    drive(I_NONE);
  endtask

  task automatic chk(input string name, input logic [17:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (st,tick,load,ball,sl,sr,win,pa,go)", name, obs, exp);
    end
  endtask

  // Three seconds of GOAL then one second of KICKOFF back into play.
  task automatic goal_to_play(input int sl, input int sr);
    step(I_SEC); chk("goal_sec1", mk(4, 0, 0, 0, sl, sr, 0, 0, 0));
    step(I_SEC); chk("goal_sec2", mk(4, 0, 0, 0, sl, sr, 0, 0, 0));
    step(I_SEC); chk("goal_to_kick", mk(1, 0, 0, 1, sl, sr, 0, 0, 0));
    step(I_SEC); chk("kick_to_play", mk(2, 0, 0, 0, sl, sr, 0, 1, 0));
  endtask

  initial begin
    vecs[0]  = '{I_NONE,          mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{I_START,         mk(1, 0, 1, 1, 0, 0, 0, 0, 0)};
    vecs[2]  = '{I_NONE,          mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{I_SEC,           mk(2, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[4]  = '{I_SEC,           mk(2, 1, 0, 0, 0, 0, 0, 1, 0)};
    vecs[5]  = '{I_NONE,          mk(2, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[6]  = '{I_GL,            mk(4, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[7]  = '{I_SEC,           mk(4, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[8]  = '{I_SEC,           mk(4, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[9]  = '{I_SEC,           mk(1, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[10] = '{I_GL | I_PAUSE,  mk(1, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[11] = '{I_SEC,           mk(2, 0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[12] = '{I_PAUSE,         mk(3, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[13] = '{I_SEC,           mk(3, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[14] = '{I_SEC | I_GR,    mk(3, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[15] = '{I_SEC,           mk(3, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[16] = '{I_SEC,           mk(3, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[17] = '{I_PAUSE,         mk(2, 0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[18] = '{I_SEC,           mk(2, 1, 0, 0, 1, 0, 0, 1, 0)};
    vecs[19] = '{I_START,         mk(2, 0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[20] = '{I_TUP,           mk(5, 0, 0, 0, 1, 0, 1, 0, 1)};
    vecs[21] = '{I_SEC,           mk(5, 0, 0, 0, 1, 0, 1, 0, 1)};
    vecs[22] = '{I_START,         mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

    drive(I_NONE);
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].in);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Left wins 5-0
    step(I_START); chk("win_start", mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
    step(I_SEC);   chk("win_play", mk(2, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int g = 1; g <= 4; g++) begin
      step(I_GL); chk($sformatf("win_goal%0d", g), mk(4, 0, 0, 0, g, 0, 0, 0, 0));
      goal_to_play(g, 0);
    end
    step(I_GL);    chk("win_fifth", mk(5, 0, 0, 0, 5, 0, 1, 0, 1));
    step(I_SEC);   chk("win_hold", mk(5, 0, 0, 0, 5, 0, 1, 0, 1));
    step(I_START); chk("win_to_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // 2-2, then both goals with time_up: draw
    step(I_START);
    step(I_SEC);
    for (int r = 1; r <= 2; r++) begin
      step(I_GL); chk("draw_gl", mk(4, 0, 0, 0, r, r - 1, 0, 0, 0));
      goal_to_play(r, r - 1);
      step(I_GR); chk("draw_gr", mk(4, 0, 0, 0, r, r, 0, 0, 0));
      goal_to_play(r, r);
    end
    step(I_GL | I_GR | I_TUP); chk("draw_over", mk(5, 0, 0, 0, 3, 3, 3, 0, 1));
    step(I_START); chk("draw_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Right leads when time runs out
    step(I_START);
    step(I_SEC);
    step(I_GR);    chk("right_goal", mk(4, 0, 0, 0, 0, 1, 0, 0, 0));
    goal_to_play(0, 1);
    step(I_TUP);   chk("right_over", mk(5, 0, 0, 0, 0, 1, 2, 0, 1));
    step(I_START); chk("right_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset while in GOAL with the second counter at 2
    step(I_START);
    step(I_SEC);
    step(I_GL);
    step(I_SEC);   chk("rst_pre", mk(4, 0, 0, 0, 1, 0, 0, 0, 0));
    #2;
    resetN = 1'b0;
    #1;
    chk("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_SEC);   chk("rst_held", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetN = 1'b1;
    step(I_SEC);   chk("rst_rel1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_SEC);   chk("rst_rel2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_NONE);  chk("rst_rel3", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
